// File: rtl/result_drain.sv
// Result SRAM drain engine: walks sets a, b, c row by row and streams each row out
// through a 2-entry FIFO that hides the one-cycle SRAM read latency under backpressure.
module result_drain #(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH        = 6,
  parameter int NUM_ROWS          = 64
) (
  input  logic                                      clk,
  input  logic                                      srst,
  input  logic                                      drain_start,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_a,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_b,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_c,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   out_data,
  output logic [1:0]                                out_set,
  output logic [ADDR_WIDTH-1:0]                     out_row,
  output logic                                      out_last,
  output logic                                      drain_busy,
  output logic                                      drain_done
);

  localparam int RW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [RW-1:0]         data;
    logic [1:0]            set;
    logic [ADDR_WIDTH-1:0] row;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic                  done_d, done_q;
  logic [1:0]            set_q;
  logic [ADDR_WIDTH-1:0] row_q;
  logic                  pend_q;
  logic [1:0]            pend_set_q;
  logic [ADDR_WIDTH-1:0] pend_row_q;

  entry_t                fifo_mem [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  push, pop, issue, last_issue;
  logic [2:0]            occ_after;
  entry_t                push_entry;

  assign out_valid  = (count_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign push       = pend_q;

  // Occupancy the FIFO would reach if every read in flight lands and the head pops now.
  assign occ_after  = {1'b0, count_q} + {2'b0, pend_q} - {2'b0, pop};
  assign issue      = (state_q == S_READ) && (occ_after < 3'd2);
  assign last_issue = issue && (set_q == 2'd2) && (row_q == LAST_ROW);

  assign out_data   = fifo_mem[rd_ptr_q].data;
  assign out_set    = fifo_mem[rd_ptr_q].set;
  assign out_row    = fifo_mem[rd_ptr_q].row;
  assign out_last   = fifo_mem[rd_ptr_q].last;
  assign drain_busy = (state_q != S_IDLE);
  assign drain_done = done_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (drain_start) state_d = S_READ;
      S_READ:  if (last_issue) state_d = S_FLUSH;
      S_FLUSH: begin
        if (count_q == 2'd0 && !pend_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_entry.data = sram_rdata_a;
    case (pend_set_q)
      2'd1:    push_entry.data = sram_rdata_b;
      2'd2:    push_entry.data = sram_rdata_c;
      default: push_entry.data = sram_rdata_a;
    endcase
    push_entry.set  = pend_set_q;
    push_entry.row  = pend_row_q;
    push_entry.last = (pend_set_q == 2'd2) && (pend_row_q == LAST_ROW);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      set_q        <= 2'd0;
      row_q        <= '0;
      pend_q       <= 1'b0;
      pend_set_q   <= 2'd0;
      pend_row_q   <= '0;
      sram_raddr_a <= '0;
      sram_raddr_b <= '0;
      sram_raddr_c <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pend_q  <= issue;
      if (state_q == S_IDLE && drain_start) begin
        set_q <= 2'd0;
        row_q <= '0;
      end else if (issue) begin
        pend_set_q <= set_q;
        pend_row_q <= row_q;
        case (set_q)
          2'd0:    sram_raddr_a <= row_q;
          2'd1:    sram_raddr_b <= row_q;
          default: sram_raddr_c <= row_q;
        endcase
        if (row_q == LAST_ROW) begin
          row_q <= '0;
          set_q <= set_q + 2'd1;
        end else begin
          row_q <= row_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // NOTE: the two FIFO slots are reset because the head is visible on out_data/set/row and must read zero after reset.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= push_entry;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The issue rule keeps the FIFO from overflowing; a push into a full FIFO without a pop is a design error.
  a_no_overflow: assert property (@(posedge clk) disable iff (srst)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: table of drain scenarios against a queue-based
// expected-transfer model, plus hand-written reset-abort and single-row sequences.
module tb_result_drain;

  localparam int AS = 8;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NR = 64;
  localparam int RW = AS * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst, drain_start, out_ready;
  logic [AW-1:0] sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [RW-1:0] sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic          out_valid, out_last, drain_busy, drain_done;
  logic [RW-1:0] out_data;
  logic [1:0]    out_set;
  logic [AW-1:0] out_row;

  logic          drain_start1, out_ready1;
  logic [AW-1:0] raddr1_a, raddr1_b, raddr1_c;
  logic [RW-1:0] rdata1_a, rdata1_b, rdata1_c;
  logic          out_valid1, out_last1, drain_busy1, drain_done1;
  logic [RW-1:0] out_data1;
  logic [1:0]    out_set1;
  logic [AW-1:0] out_row1;

  int unsigned salt;
  int          vectors;
  int          miscompares;

  // Each SRAM row carries its set, row, lane index and a per-drain salt.
  function automatic logic [RW-1:0] row_pattern(int s, int r, int unsigned slt);
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < AS; i++) v[i*DW +: DW] = {2'(s), 6'(r), 3'(i), 5'(slt)};
    return v;
  endfunction

  assign sram_rdata_a = row_pattern(0, int'(sram_raddr_a), salt);
  assign sram_rdata_b = row_pattern(1, int'(sram_raddr_b), salt);
  assign sram_rdata_c = row_pattern(2, int'(sram_raddr_c), salt);
  assign rdata1_a     = row_pattern(0, int'(raddr1_a), salt);
  assign rdata1_b     = row_pattern(1, int'(raddr1_b), salt);
  assign rdata1_c     = row_pattern(2, int'(raddr1_c), salt);

  result_drain #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ROWS(NR)) dut (
    .clk(clk), .srst(srst), .drain_start(drain_start),
    .sram_raddr_a(sram_raddr_a), .sram_raddr_b(sram_raddr_b), .sram_raddr_c(sram_raddr_c),
    .sram_rdata_a(sram_rdata_a), .sram_rdata_b(sram_rdata_b), .sram_rdata_c(sram_rdata_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_set(out_set),
    .out_row(out_row), .out_last(out_last), .drain_busy(drain_busy), .drain_done(drain_done)
  );

  result_drain #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ROWS(1)) dut1 (
    .clk(clk), .srst(srst), .drain_start(drain_start1),
    .sram_raddr_a(raddr1_a), .sram_raddr_b(raddr1_b), .sram_raddr_c(raddr1_c),
    .sram_rdata_a(rdata1_a), .sram_rdata_b(rdata1_b), .sram_rdata_c(rdata1_c),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_set(out_set1),
    .out_row(out_row1), .out_last(out_last1), .drain_busy(drain_busy1), .drain_done(drain_done1)
  );

  typedef struct {
    logic [RW-1:0] data;
    int            set;
    int            row;
    bit            last;
  } xfer_t;

  // mode: 0 ready always, 1 ready toggles, 2 ready random, 3 ready held low for 20 cycles
  typedef struct {
    int mode;
    int start_pulse_at;
    int exp_xfers;
    int exp_cycles;
  } vec_t;

  xfer_t exp_q[$];

  task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_model(int n);
    exp_q.delete();
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < n; r++)
        exp_q.push_back('{row_pattern(s, r, salt), s, r, (s == 2 && r == n - 1)});
  endtask

  task automatic compare_head();
    xfer_t e;
    if (exp_q.size() == 0) begin
      check("unexpected extra transfer", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("out_data", out_data, e.data);
      check("out_set", out_set, e.set);
      check("out_row", out_row, e.row);
      check("out_last", out_last, e.last);
    end
  endtask

  task automatic run_drain(vec_t v);
    int            cyc, xfers, extra_done;
    bit            done_seen, stalled;
    logic [RW-1:0] held_data;
    logic [1:0]    held_set;
    logic [AW-1:0] held_row;
    salt = $urandom;
    build_model(NR);
    cyc = 0; xfers = 0; done_seen = 0; stalled = 0;
    held_data = '0; held_set = '0; held_row = '0;
    @(negedge clk);
    drain_start = 1'b1;
    out_ready   = 1'b0;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      drain_start = (cyc == v.start_pulse_at);
      case (v.mode)
        1:       out_ready = (cyc % 2 == 1);
        2:       out_ready = ($urandom_range(3) != 0);
        3:       out_ready = (cyc > 20);
        default: out_ready = 1'b1;
      endcase
      if (cyc == 1) check("drain_busy after start", drain_busy, 1);
      if (v.mode == 3 && cyc == 20) begin
        check("raddr_a held at row 1 while stalled", sram_raddr_a, 1);
        check("out_valid with full fifo", out_valid, 1);
      end
      if (v.mode == 3 && cyc == 22) check("raddr_a resumes at row 2", sram_raddr_a, 2);
      if (stalled) begin
        check("stall valid held", out_valid, 1);
        check("stall data held", out_data, held_data);
        check("stall tag held", {out_set, out_row}, {held_set, held_row});
      end
      if (drain_done) begin
        done_seen = 1;
        if (v.exp_cycles >= 0) check("start to done cycles", cyc - 1, v.exp_cycles);
      end
      if (out_valid && out_ready) begin
        compare_head();
        xfers++;
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_set  = out_set;
      held_row  = out_row;
    end
    drain_start = 1'b0;
    check("drain_done seen", done_seen, 1);
    check("transfer count", xfers, v.exp_xfers);
    check("model queue drained", exp_q.size(), 0);
    @(negedge clk);
    check("drain_done single pulse", drain_done, 0);
    check("drain_busy cleared", drain_busy, 0);
    extra_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (drain_done || out_valid) extra_done++;
    end
    check("quiet after drain", extra_done, 0);
    out_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int n, dones, cyc, xfers;
    bit done_seen;
    vecs[0] = '{0, 0, 3 * NR, 3 * NR + 3};
    vecs[1] = '{1, 0, 3 * NR, -1};
    vecs[2] = '{2, 0, 3 * NR, -1};
    vecs[3] = '{3, 0, 3 * NR, -1};
    vecs[4] = '{0, 50, 3 * NR, 3 * NR + 3};
    vecs[5] = '{2, 0, 3 * NR, -1};

    vectors = 0; miscompares = 0; salt = 0;
    srst = 1'b1; drain_start = 1'b0; out_ready = 1'b0;
    drain_start1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out tags", {out_set, out_row, out_last}, 0);
    check("reset raddr", {sram_raddr_a, sram_raddr_b, sram_raddr_c}, 0);
    check("reset busy/done", {drain_busy, drain_done}, 0);

    for (int i = 0; i < 6; i++) run_drain(vecs[i]);

    // Reset while transfer #100 (set b, row 35) is presented: aborts with no done.
    salt = $urandom;
    build_model(NR);
    @(negedge clk);
    drain_start = 1'b1;
    out_ready   = 1'b1;
    n = 0; cyc = 0;
    while (n < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      drain_start = 1'b0;
      if (out_valid && out_ready) n++;
    end
    check("reached transfer 100", n, 100);
    check("transfer 100 tag", {out_set, out_row}, {2'd1, 6'd35});
    srst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort raddr", {sram_raddr_a, sram_raddr_b, sram_raddr_c}, 0);
    check("abort busy", drain_busy, 0);
    @(negedge clk);
    srst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (drain_done) dones++;
    end
    check("no done after abort", dones, 0);
    run_drain(vecs[0]);

    // Single-row configuration: a0, b0, c0 with set wrap on every row.
    salt = $urandom;
    build_model(1);
    @(negedge clk);
    drain_start1 = 1'b1;
    out_ready1   = 1'b1;
    cyc = 0; xfers = 0; done_seen = 0;
    while (!done_seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      drain_start1 = 1'b0;
      if (drain_done1) begin
        done_seen = 1;
        check("n1 start to done cycles", cyc - 1, 6);
      end
      if (out_valid1) begin
        if (exp_q.size() == 0) begin
          check("n1 unexpected extra transfer", 1, 0);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("n1 out_data", out_data1, e.data);
          check("n1 out_set", out_set1, e.set);
          check("n1 out_row", out_row1, e.row);
          check("n1 out_last", out_last1, e.last);
        end
        xfers++;
      end
    end
    check("n1 drain_done seen", done_seen, 1);
    check("n1 transfer count", xfers, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
